// File: rtl/pipes.sv
// Shared definitions for the iterative multiply/divide unit: operation
// encoding, FSM states, widths and per-operation decode helpers.
package pipes;

  localparam int MULDIV_XLEN = 64;
  localparam int MULDIV_WLEN = 32;

  typedef enum logic [3:0] {
    MUL    = 4'd0,
    MULH   = 4'd1,
    MULHU  = 4'd2,
    MULHSU = 4'd3,
    MULW   = 4'd4,
    DIV    = 4'd5,
    DIVU   = 4'd6,
    REM    = 4'd7,
    REMU   = 4'd8,
    DIVW   = 4'd9,
    DIVUW  = 4'd10,
    REMW   = 4'd11,
    REMUW  = 4'd12
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } muldiv_state_e;

  function automatic logic op_is_div(input muldiv_op_e op);
    case (op)
      DIV, DIVU, REM, REMU, DIVW, DIVUW, REMW, REMUW: op_is_div = 1'b1;
      default:                                        op_is_div = 1'b0;
    endcase
  endfunction

  function automatic logic op_is_w(input muldiv_op_e op);
    case (op)
      MULW, DIVW, DIVUW, REMW, REMUW: op_is_w = 1'b1;
      default:                        op_is_w = 1'b0;
    endcase
  endfunction

  function automatic logic op_is_rem(input muldiv_op_e op);
    case (op)
      REM, REMU, REMW, REMUW: op_is_rem = 1'b1;
      default:                op_is_rem = 1'b0;
    endcase
  endfunction

  function automatic logic op_is_mulh(input muldiv_op_e op);
    case (op)
      MULH, MULHU, MULHSU: op_is_mulh = 1'b1;
      default:             op_is_mulh = 1'b0;
    endcase
  endfunction

  function automatic logic op_src1_signed(input muldiv_op_e op);
    case (op)
      MUL, MULH, MULHSU, MULW, DIV, REM, DIVW, REMW: op_src1_signed = 1'b1;
      default:                                      op_src1_signed = 1'b0;
    endcase
  endfunction

  function automatic logic op_src2_signed(input muldiv_op_e op);
    case (op)
      MUL, MULH, MULW, DIV, REM, DIVW, REMW: op_src2_signed = 1'b1;
      default:                              op_src2_signed = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration on magnitudes: shift-add multiply on {hi,lo} with lo
// as multiplier, or restoring shift-subtract divide with hi as partial remainder.
module muldiv_step
  import pipes::*;
(
  input  logic                   is_div,
  input  logic [MULDIV_XLEN-1:0] hi,
  input  logic [MULDIV_XLEN-1:0] lo,
  input  logic [MULDIV_XLEN-1:0] b,
  output logic [MULDIV_XLEN-1:0] hi_next,
  output logic [MULDIV_XLEN-1:0] lo_next
);

  logic [MULDIV_XLEN:0] add_sum;
  logic [MULDIV_XLEN:0] shifted;
  logic                 ge;

  always_comb begin
    add_sum = {1'b0, hi} + (lo[0] ? {1'b0, b} : '0);
    shifted = {hi, lo[MULDIV_XLEN-1]};
    ge      = (shifted >= {1'b0, b});
    hi_next = '0;
    lo_next = '0;
    if (is_div) begin
      // A 65-bit shifted remainder always exceeds b, so the difference fits 64 bits.
      hi_next = ge ? (shifted[MULDIV_XLEN-1:0] - b) : shifted[MULDIV_XLEN-1:0];
      lo_next = {lo[MULDIV_XLEN-2:0], ge};
    end else begin
      hi_next = add_sum[MULDIV_XLEN:1];
      lo_next = {add_sum[0], lo[MULDIV_XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Iterative multiply/divide controller: IDLE/CALC/DONE FSM with iteration counter,
// operand preparation, divide special cases and sign fix-up of the final result.
module muldiv_ctrl
  import pipes::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [3:0]             op,
  input  logic [MULDIV_XLEN-1:0] src1,
  input  logic [MULDIV_XLEN-1:0] src2,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [MULDIV_XLEN-1:0] result,
  output logic                   busy
);

  localparam logic [MULDIV_XLEN-1:0] X_MIN = 64'h8000_0000_0000_0000;
  localparam logic [MULDIV_XLEN-1:0] W_MIN = 64'hFFFF_FFFF_8000_0000;

  muldiv_state_e          state;
  muldiv_op_e             op_q;
  logic [6:0]             cnt;
  logic [MULDIV_XLEN-1:0] hi_q, lo_q, b_q;
  logic                   neg_a_q, neg_b_q;

  muldiv_op_e             op_in;
  logic                   in_w, in_div, in_s1, in_s2;
  logic [MULDIV_XLEN-1:0] a_val, b_val, mag_a, mag_b;
  logic                   neg_a, neg_b, div_zero, div_ovf;
  logic [MULDIV_XLEN-1:0] early_res;
  logic [MULDIV_XLEN-1:0] hi_n, lo_n;
  logic [6:0]             last_cnt;

  function automatic logic [MULDIV_XLEN-1:0] sext_w(input logic [MULDIV_WLEN-1:0] v);
    sext_w = {{(MULDIV_XLEN-MULDIV_WLEN){v[MULDIV_WLEN-1]}}, v};
  endfunction

  function automatic logic [MULDIV_XLEN-1:0] fixup(
    input muldiv_op_e             f_op,
    input logic                   f_neg_a,
    input logic                   f_neg_b,
    input logic [MULDIV_XLEN-1:0] f_hi,
    input logic [MULDIV_XLEN-1:0] f_lo
  );
    logic [2*MULDIV_XLEN-1:0] prod;
    logic [MULDIV_XLEN-1:0]   q, r, v;
    if (op_is_div(f_op)) begin
      q = f_lo;
      r = f_hi;
      if (f_neg_a ^ f_neg_b) q = -q;
      if (f_neg_a)           r = -r;
      v = op_is_rem(f_op) ? r : q;
    end else begin
      // W multiplies run half the iterations, leaving the product 32 bits high.
      prod = op_is_w(f_op) ? {32'd0, f_hi, f_lo[MULDIV_XLEN-1:MULDIV_WLEN]} : {f_hi, f_lo};
      if (f_neg_a ^ f_neg_b) prod = -prod;
      v = op_is_mulh(f_op) ? prod[2*MULDIV_XLEN-1:MULDIV_XLEN] : prod[MULDIV_XLEN-1:0];
    end
    fixup = op_is_w(f_op) ? sext_w(v[MULDIV_WLEN-1:0]) : v;
  endfunction

  always_comb begin
    op_in  = muldiv_op_e'(op);
    in_w   = op_is_w(op_in);
    in_div = op_is_div(op_in);
    in_s1  = op_src1_signed(op_in);
    in_s2  = op_src2_signed(op_in);
    a_val  = src1;
    b_val  = src2;
    if (in_w) begin
      a_val = in_s1 ? sext_w(src1[MULDIV_WLEN-1:0]) : {32'd0, src1[MULDIV_WLEN-1:0]};
      b_val = in_s2 ? sext_w(src2[MULDIV_WLEN-1:0]) : {32'd0, src2[MULDIV_WLEN-1:0]};
    end
    neg_a    = in_s1 & a_val[MULDIV_XLEN-1];
    neg_b    = in_s2 & b_val[MULDIV_XLEN-1];
    mag_a    = neg_a ? -a_val : a_val;
    mag_b    = neg_b ? -b_val : b_val;
    div_zero = in_div && (b_val == '0);
    div_ovf  = in_div && in_s1 && (a_val == (in_w ? W_MIN : X_MIN)) && (b_val == '1);
    if (div_zero) early_res = op_is_rem(op_in) ? a_val : '1;
    else          early_res = op_is_rem(op_in) ? '0 : a_val;
    if (in_w) early_res = sext_w(early_res[MULDIV_WLEN-1:0]);
    last_cnt = op_is_w(op_q) ? 7'd31 : 7'd63;
  end

  muldiv_step u_step (
    .is_div  (op_is_div(op_q)),
    .hi      (hi_q),
    .lo      (lo_q),
    .b       (b_q),
    .hi_next (hi_n),
    .lo_next (lo_n)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      op_q      <= MUL;
      cnt       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      b_q       <= '0;
      neg_a_q   <= 1'b0;
      neg_b_q   <= 1'b0;
      result    <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b0;
    end else if (flush) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            op_q     <= op_in;
            neg_a_q  <= neg_a;
            neg_b_q  <= neg_b;
            cnt      <= '0;
            hi_q     <= '0;
            busy     <= 1'b1;
            in_ready <= 1'b0;
            // Multiply: lo is the multiplier. Divide: lo is the dividend, top-aligned for W ops.
            if (in_div) begin
              lo_q <= in_w ? {mag_a[MULDIV_WLEN-1:0], 32'd0} : mag_a;
              b_q  <= mag_b;
            end else begin
              lo_q <= mag_b;
              b_q  <= mag_a;
            end
            if (div_zero || div_ovf) begin
              result    <= early_res;
              out_valid <= 1'b1;
              state     <= ST_DONE;
            end else begin
              state <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          hi_q <= hi_n;
          lo_q <= lo_n;
          cnt  <= cnt + 7'd1;
          if (cnt == last_cnt) begin
            result    <= fixup(op_q, neg_a_q, neg_b_q, hi_n, lo_n);
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: expected results queued at issue, popped and
// compared when out_valid appears, plus latency, flush, backpressure and reset cases.
module tb_muldiv_ctrl;
  import pipes::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  op = 4'd0;
  logic [63:0] src1 = '0;
  logic [63:0] src2 = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] result;
  logic        busy;

  int checks = 0;
  int failures = 0;
  logic [63:0] exp_q[$];

  muldiv_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .src1      (src1),
    .src2      (src2),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one operation and hold it until the accepting edge has passed.
  task automatic send(input muldiv_op_e o, input logic [63:0] a, input logic [63:0] b);
    int guard;
    guard = 0;
    while (in_ready !== 1'b1 && guard < 200) begin
      tick();
      guard++;
    end
    check("in_ready_before_issue", 64'(in_ready), 64'd1);
    op       = 4'(o);
    src1     = a;
    src2     = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic issue(input muldiv_op_e o, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] exp);
    exp_q.push_back(exp);
    send(o, a, b);
  endtask

  task automatic collect(input string tag, input int exp_lat, input int hold);
    int          lat;
    logic        rdy_seen;
    logic        ok;
    logic [63:0] exp;
    logic [63:0] r0;
    lat      = 1;
    rdy_seen = 1'b0;
    while (out_valid !== 1'b1 && lat < 200) begin
      if (in_ready !== 1'b0) rdy_seen = 1'b1;
      tick();
      lat++;
    end
    exp = exp_q.pop_front();
    check({tag, " out_valid"}, 64'(out_valid), 64'd1);
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " in_ready_low"}, 64'(rdy_seen), 64'd0);
    check({tag, " result"}, result, exp);
    if (hold > 0) begin
      r0 = result;
      ok = 1'b1;
      repeat (hold) begin
        tick();
        if (out_valid !== 1'b1 || result !== r0 || busy !== 1'b1 || in_ready !== 1'b0) ok = 1'b0;
      end
      check({tag, " hold_stable"}, 64'(ok), 64'd1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, " released"}, 64'(out_valid), 64'd0);
  endtask

  initial begin : main
    logic seen;

    // Reset state
    repeat (2) tick();
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst in_ready", 64'(in_ready), 64'd0);
    check("rst result", result, 64'd0);
    reset = 1'b1;
    tick();
    check("post_rst in_ready", 64'(in_ready), 64'd1);

    // Multiply and divide, full and W widths
    issue(MUL, 64'd7, -64'sd3, 64'hFFFF_FFFF_FFFF_FFEB);
    collect("mul_7x-3", 65, 0);
    issue(DIVW, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000);
    collect("divw_ovf", 1, 0);
    issue(REMW, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'd0);
    collect("remw_ovf", 1, 0);
    issue(DIVU, 64'd1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    collect("divu_zero", 1, 0);
    issue(REMU, 64'd42, 64'd0, 64'd42);
    collect("remu_zero", 1, 0);
    issue(REM, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF);
    collect("rem_-7_2", 65, 0);
    issue(MULHU, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE);
    collect("mulhu_ones", 65, 0);
    issue(DIVW, 64'h0000_0000_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2);
    collect("divw_-100_7", 33, 0);
    issue(REMW, 64'h0000_0000_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE);
    collect("remw_-100_7", 33, 0);
    issue(MULW, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE);
    collect("mulw_wrap", 33, 0);
    issue(DIV, 64'd100, -64'sd7, 64'hFFFF_FFFF_FFFF_FFF2);
    collect("div_100_-7", 65, 0);
    issue(MULHSU, -64'sd1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF);
    collect("mulhsu", 65, 0);
    issue(DIVUW, 64'hABCD_0000_FFFF_FFFF, 64'd2, 64'h0000_0000_7FFF_FFFF);
    collect("divuw", 33, 0);
    issue(DIV, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000);
    collect("div_ovf", 1, 0);
    issue(REM, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
    collect("rem_ovf", 1, 0);
    issue(REMUW, 64'h1234_5678_9ABC_DEF0, 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_9ABC_DEF0);
    collect("remuw_zero", 1, 0);

    // Flush at the tenth CALC cycle
    send(MUL, 64'd5, 64'd9);
    repeat (9) tick();
    check("flush busy_before", 64'(busy), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush out_valid", 64'(out_valid), 64'd0);
    check("flush in_ready", 64'(in_ready), 64'd1);
    check("flush busy", 64'(busy), 64'd0);
    seen = 1'b0;
    repeat (70) begin
      if (out_valid !== 1'b0) seen = 1'b1;
      tick();
    end
    check("flush no_out_valid", 64'(seen), 64'd0);
    issue(MUL, 64'h0000_0001_2345_6789, 64'h10, 64'h0000_0012_3456_7890);
    collect("mul_after_flush", 65, 0);

    // Consumer backpressure for five cycles
    issue(MULH, 64'h4000_0000_0000_0000, 64'd4, 64'd1);
    collect("mulh_backpressure", 65, 5);

    // Reset pulse in the middle of CALC
    send(DIV, 64'd1000, 64'd3);
    repeat (5) tick();
    #2 reset = 1'b0;
    #1;
    check("midrst out_valid", 64'(out_valid), 64'd0);
    check("midrst busy", 64'(busy), 64'd0);
    check("midrst in_ready", 64'(in_ready), 64'd0);
    check("midrst result", result, 64'd0);
    tick();
    reset = 1'b1;
    tick();
    check("midrst in_ready_after", 64'(in_ready), 64'd1);
    seen = 1'b0;
    repeat (80) begin
      if (out_valid !== 1'b0) seen = 1'b1;
      tick();
    end
    check("midrst no_out_valid", 64'(seen), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
